// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq
// Brief    : 16-bit unsigned MUL / DIVU sequencer that borrows a shared
//            combinational ALU (shift-add multiply, restoring divide).
//            Define NLP_MULDIV_DIV_EN to build the divide datapath.
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_op,
   input  logic [15:0] i_op_a,
   input  logic [15:0] i_op_b,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_result_lo,
   output logic [15:0] o_result_hi,
   output logic        o_err,
   output logic [5:0]  o_alu_ctrl,
   output logic [15:0] o_alu_a,
   output logic [15:0] o_alu_b,
   output logic        o_alu_carry,
   input  logic [15:0] i_alu_data,
   input  logic [3:0]  i_alu_flag
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [5:0] C_ALU_PASS  = 6'h00;
   localparam logic [5:0] C_ALU_ADD   = 6'h0A;
   localparam logic [5:0] C_ALU_SUB   = 6'h09;
   localparam logic [3:0] C_LAST_ITER = 4'd15;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [15:0] r_opnd;
   logic [15:0] r_hi;
   logic [15:0] r_lo;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic [15:0] r_res_lo;
   logic [15:0] r_res_hi;

   logic        w_run;
   logic        w_carry;
   logic [16:0] w_mul_sum;
   logic [15:0] w_mul_hi;
   logic [15:0] w_mul_lo;
   logic [15:0] w_nxt_hi;
   logic [15:0] w_nxt_lo;
   logic        w_unused_flags;

   assign w_run          = (r_state == S_RUN);
   assign w_carry        = i_alu_flag[3];
   assign w_unused_flags = &{1'b0, i_alu_flag[2:0]};

   // {acc_hi, mq} shifts right as one 33-bit value with the adder carry on top
   assign w_mul_sum = r_lo[0] ? {w_carry, i_alu_data} : {1'b0, r_hi};
   assign w_mul_hi  = w_mul_sum[16:1];
   assign w_mul_lo  = {w_mul_sum[0], r_lo[15:1]};

`ifdef NLP_MULDIV_DIV_EN
   logic        r_op;
   logic [16:0] w_div_t;
   logic        w_div_ok;
   logic [15:0] w_div_hi;
   logic [15:0] w_div_lo;

   // t[16] set means the partial remainder already exceeds 16 bits
   assign w_div_t  = {r_hi, r_lo[15]};
   assign w_div_ok = w_div_t[16] | ~w_carry;
   assign w_div_hi = w_div_ok ? i_alu_data : w_div_t[15:0];
   assign w_div_lo = {r_lo[14:0], w_div_ok};

   assign w_nxt_hi   = r_op ? w_div_hi : w_mul_hi;
   assign w_nxt_lo   = r_op ? w_div_lo : w_mul_lo;
   assign o_alu_ctrl = !w_run ? C_ALU_PASS : (r_op ? C_ALU_SUB : C_ALU_ADD);
   assign o_alu_a    = !w_run ? 16'h0000 : (r_op ? w_div_t[15:0] : r_hi);
`else
   assign w_nxt_hi   = w_mul_hi;
   assign w_nxt_lo   = w_mul_lo;
   assign o_alu_ctrl = w_run ? C_ALU_ADD : C_ALU_PASS;
   assign o_alu_a    = w_run ? r_hi : 16'h0000;
`endif

   assign o_alu_b     = w_run ? r_opnd : 16'h0000;
   assign o_alu_carry = 1'b0;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 4'd0;
         r_opnd   <= 16'h0000;
         r_hi     <= 16'h0000;
         r_lo     <= 16'h0000;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_res_lo <= 16'h0000;
         r_res_hi <= 16'h0000;
`ifdef NLP_MULDIV_DIV_EN
         r_op     <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_cnt  <= 4'd0;
                  r_busy <= 1'b1;
                  r_err  <= 1'b0;
                  r_hi   <= 16'h0000;
`ifdef NLP_MULDIV_DIV_EN
                  r_op   <= i_op;
                  r_opnd <= i_op ? i_op_b : i_op_a;
                  r_lo   <= i_op ? i_op_a : i_op_b;
                  if (i_op && (i_op_b == 16'h0000)) begin
                     r_state  <= S_DONE;
                     r_done   <= 1'b1;
                     r_err    <= 1'b1;
                     r_res_lo <= 16'hFFFF;
                     r_res_hi <= i_op_a;
                  end else begin
                     r_state <= S_RUN;
                  end
`else
                  r_opnd <= i_op_a;
                  r_lo   <= i_op_b;
                  if (i_op) begin
                     r_state  <= S_DONE;
                     r_done   <= 1'b1;
                     r_err    <= 1'b1;
                     r_res_lo <= 16'h0000;
                     r_res_hi <= 16'h0000;
                  end else begin
                     r_state <= S_RUN;
                  end
`endif
               end
            end
            S_RUN: begin
               r_hi  <= w_nxt_hi;
               r_lo  <= w_nxt_lo;
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == C_LAST_ITER) begin
                  r_state  <= S_DONE;
                  r_done   <= 1'b1;
                  r_res_hi <= w_nxt_hi;
                  r_res_lo <= w_nxt_lo;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_err       = r_err;
   assign o_result_lo = r_res_lo;
   assign o_result_hi = r_res_hi;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv_seq
// Brief    : directed self-checking bench for alu_muldiv_seq with an ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_muldiv_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        op;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        busy;
   logic        done;
   logic [15:0] res_lo;
   logic [15:0] res_hi;
   logic        err;
   logic [5:0]  alu_ctrl;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic        alu_carry;
   logic [15:0] alu_data;
   logic [3:0]  alu_flag;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_muldiv_seq u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_op        (op),
      .i_op_a      (op_a),
      .i_op_b      (op_b),
      .o_busy      (busy),
      .o_done      (done),
      .o_result_lo (res_lo),
      .o_result_hi (res_hi),
      .o_err       (err),
      .o_alu_ctrl  (alu_ctrl),
      .o_alu_a     (alu_a),
      .o_alu_b     (alu_b),
      .o_alu_carry (alu_carry),
      .i_alu_data  (alu_data),
      .i_alu_flag  (alu_flag)
   );

   // Shared ALU: 0x0A add (C = carry out), 0x09 subtract (C = borrow)
   logic [16:0] alu_wide;
   always_comb begin
      alu_wide = {1'b0, alu_a};
      case (alu_ctrl)
         6'h0A:   alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
         6'h09:   alu_wide = {(alu_a < alu_b), alu_a - alu_b};
         default: alu_wide = {1'b0, alu_a};
      endcase
      alu_data = alu_wide[15:0];
      alu_flag = {alu_wide[16], alu_wide[15], 1'b0, (alu_wide[15:0] == 16'h0000)};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},  {31'd0, busy}, 32'd0);
      check({tag, "_done"},  {31'd0, done}, 32'd0);
      check({tag, "_err"},   {31'd0, err}, 32'd0);
      check({tag, "_res"},   {res_hi, res_lo}, 32'd0);
      check({tag, "_ctrl"},  {26'd0, alu_ctrl}, 32'd0);
      check({tag, "_ab"},    {alu_a, alu_b}, 32'd0);
      check({tag, "_carry"}, {31'd0, alu_carry}, 32'd0);
   endtask

   // Issue one operation and follow it to o_done, checking ALU drive each cycle
   task automatic do_op(input logic o, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] e_hi, input logic [15:0] e_lo,
                        input logic e_err, input int e_lat, input string tag);
      int  n;
      bit  got;
      logic [5:0] e_ctrl;
      @(negedge clk);
      start = 1'b1; op = o; op_a = a; op_b = b;
      @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      got = 1'b0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         e_ctrl = (e_lat == 17 && n <= 16) ? (o ? 6'h09 : 6'h0A) : 6'h00;
         check({tag, "_ctrl"},  {26'd0, alu_ctrl}, {26'd0, e_ctrl});
         check({tag, "_carry"}, {31'd0, alu_carry}, 32'd0);
         check({tag, "_busy"},  {31'd0, busy}, 32'd1);
         if (done) got = 1'b1;
      end
      check({tag, "_lat"}, n, e_lat);
      check({tag, "_res"}, {res_hi, res_lo}, {e_hi, e_lo});
      check({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
      @(negedge clk);
      check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
      repeat (3) @(negedge clk);
      check({tag, "_hold"}, {15'd0, err, res_hi, res_lo}, {15'd0, e_err, e_hi, e_lo});
   endtask

   initial begin
      bit seen_done;
      rst = 1'b1; start = 1'b0; op = 1'b0; op_a = 16'h0; op_b = 16'h0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      do_op(1'b0, 16'h1234, 16'h5678, 16'h0626, 16'h0060, 1'b0, 17, "mul_1234");
      do_op(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 17, "mul_ffff");
      do_op(1'b0, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 17, "mul_zero");
`ifdef NLP_MULDIV_DIV_EN
      do_op(1'b1, 16'd1000, 16'd7,    16'h0006, 16'h008E, 1'b0, 17, "div_1000_7");
      do_op(1'b1, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 17, "div_ffff_1");
      do_op(1'b1, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1, 1,  "div_by_zero");
`else
      do_op(1'b1, 16'd10,   16'd3,    16'h0000, 16'h0000, 1'b1, 1,  "div_disabled");
`endif
      // clears the error left behind by the previous case
      do_op(1'b0, 16'h0002, 16'h0003, 16'h0000, 16'h0006, 1'b0, 17, "mul_2_3");

      // Start pulses inside RUN (N+5) and during DONE (N+17) must be dropped
      @(negedge clk);
      start = 1'b1; op = 1'b0; op_a = 16'h1234; op_b = 16'h5678;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= 17; n++) begin
         @(negedge clk);
         start = (n == 5 || n == 17);
         op_a  = 16'h0001;
         op_b  = 16'h0001;
         if (n == 17) begin
            check("ign_done", {31'd0, done}, 32'd1);
            check("ign_res", {res_hi, res_lo}, 32'h06260060);
         end
      end
      @(negedge clk);
      start = 1'b0;
      check("ign_busy_low", {30'd0, busy, done}, 32'd0);
      seen_done = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (done || busy) seen_done = 1'b1;
      end
      check("ign_no_rerun", {31'd0, seen_done}, 32'd0);
      check("ign_res_held", {res_hi, res_lo}, 32'h06260060);

      // Reset during RUN aborts and clears results
      @(negedge clk);
      start = 1'b1; op = 1'b0; op_a = 16'h00FF; op_b = 16'h0101;
      @(posedge clk);
      #1 start = 1'b0;
      for (int n = 1; n <= 8; n++) @(negedge clk);
      check("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1 check_zero("mid_rst");
      @(negedge clk);
      rst = 1'b0;
      seen_done = 1'b0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (done || busy) seen_done = 1'b1;
      end
      check("rst_no_done", {31'd0, seen_done}, 32'd0);
      check_zero("post_rst");

      do_op(1'b0, 16'd3, 16'd5, 16'h0000, 16'h000F, 1'b0, 17, "mul_3_5");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
